uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
Serial receive front end for the tt_um_my_project_shaazx user project. It samples the asynchronous RX pin (ui_in[3] at the top level), decodes 8N1 UART frames, and presents each received byte to the project core on a single-entry valid/ready output. It also reports framing errors and overruns. It sits directly upstream of the core logic that drives uo_out.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200 baud); legal range >= 4.
CNT_W, $clog2(CLKS_PER_BIT), bit-counter width; derived, never overridden.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset (top level drives ~rst_n)
rx  input  1  raw asynchronous serial input, idle high
out_data  output  8  received byte, LSB first on the wire
out_valid  output  1  out_data holds an unconsumed byte
out_ready  input  1  consumer accepts the byte when out_valid && out_ready
busy  output  1  high whenever the FSM is not in IDLE
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full

Behaviour:
- Reset values: out_data=0x00, out_valid=0, busy=0, frame_err=0, overrun=0. Synchronizer flops reset to 1. FSM resets to IDLE. Bit counter and bit index reset to 0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- FSM states:
  - IDLE: when rx_s==0, go to START and clear the counter.
  - START: count to CLKS_PER_BIT/2-1 (integer division). At that cycle, if rx_s==0, go to DATA with counter=0 and index=0. Otherwise it is a false start: return to IDLE with no error flagged.
  - DATA: count to CLKS_PER_BIT-1. At that cycle, shift rx_s into the MSB of the shift register (shift right) and increment the index. After the 8th sample, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s==1: deliver the byte and go to IDLE.
    - rx_s==0: pulse frame_err for one cycle, discard the byte, and go to IDLE.
  - STOP returns to IDLE at mid-stop, so a start edge immediately after the stop bit is caught.
- Delivery happens in the cycle after the stop sample:
  - If out_valid==0, or out_valid && out_ready in that cycle: load out_data and set out_valid=1.
  - If out_valid==1 && !out_ready: keep the old byte, drop the new byte, and pulse overrun for one cycle.
- Consumption: out_valid && out_ready with no simultaneous delivery clears out_valid next cycle. out_data holds its value.
- Simultaneous handshake and delivery: the new byte replaces the old one, out_valid stays 1, and overrun is not raised.
- out_data and out_valid are stable while out_valid==1 && !out_ready.
- busy = (state != IDLE), registered with the state.
- Asserting rst mid-frame aborts the frame at once and drops any pending byte. The first frame after release decodes normally. A line held low during reset is treated as a start bit once rst falls.
- frame_err and overrun never assert in the same cycle.

Test Plan:
1. CLKS_PER_BIT=8, send 0xA5 (8N1), out_ready=0 -> out_valid=1 with out_data=0xA5, held until out_ready pulses, then out_valid=0; frame_err=0, overrun=0 throughout.
2. Pull rx low for 3 cycles, then high -> busy pulses, FSM returns to IDLE, out_valid stays 0, no error pulses.
3. Send 0x3C with the stop bit forced low -> exactly one frame_err pulse, out_valid stays 0, busy=0 after mid-stop.
4. out_ready=0, send 0x11 then 0x22 back-to-back -> out_data=0x11, one overrun pulse at the second delivery. After one out_ready cycle, out_valid=0 and out_data is still 0x11.
5. out_ready=1 tied high, send 0x00, 0xFF, 0x81 back-to-back with 1-bit stop only -> three single-cycle out_valid pulses carrying 0x00, 0xFF, 0x81 in order; no overrun or frame_err.
6. Assert rst for 2 cycles during bit 4 of 0x77 -> all outputs 0 during and after reset. Then send 0x5A -> out_data=0x5A, out_valid=1.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
// 8N1 UART receiver front end. The raw rx pin is double-synchronised and
// framed by a four-state FSM that samples each bit at its midpoint. Good
// bytes are handed to a single-entry valid/ready holding register. Framing
// errors and overruns are reported as one-cycle pulses.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: half a bit to reach mid-start, then a full bit per
    // sample so every later sample also lands mid-bit.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Synchroniser
    logic             rx_meta_q;
    logic             rx_s_q;

    // Framing FSM and datapath
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       idx_q,       idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic             pend_q,      pend_d;

    // Registered outputs
    logic [7:0]       out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: frame decoding plus holding-register delivery/consume.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        idx_d       = idx_q;
        shift_d     = shift_q;
        pend_d      = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // A byte completed last cycle: accept it if the slot is free or is
        // being emptied right now, otherwise keep the old byte and flag it.
        if (pend_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // Line must still be low at mid-start, else it was a glitch.
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end

            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_STOP: begin
                // Leave at mid-stop so a start bit right after it is not missed.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s_q) begin
                        pend_d      = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
        end
    end

    // Output registers: holding slot, busy flag and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (state_d != ST_IDLE);
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: frames are generated on the wire, expected bytes
// go into a scoreboard queue, and a monitor pops/compares on every handshake.
module tb_uart_rx_frontend;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    int  exp_fe    = 0;
    int  exp_ov    = 0;
    bit  hold_full = 1'b0;

    // Monitor observations
    int  fe_seen   = 0;
    int  ov_seen   = 0;
    bit  busy_seen = 1'b0;
    bit  prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame (LSB first) and record what the consumer should see.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            if (out_ready) begin
                exp_q.push_back(b);
            end else if (hold_full) begin
                exp_ov++;
            end else begin
                exp_q.push_back(b);
                hold_full = 1'b1;
            end
        end else begin
            exp_fe++;
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok ? 1'b1 : 1'b0;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        hold_full = 1'b0;
    endtask

    // Monitor: scoreboard pops on handshakes, pulse counting, hold stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_seen = 1'b1;
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (frame_err && overrun) begin
                checks++;
                errors++;
                $display("FAIL err_ov_same_cycle frame_err=1 overrun=1 required not both");
            end
            if (prev_hold) begin
                chk("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", out_data);
                end else begin
                    chk("rx_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0;
        int ov0;
        logic [7:0] b77;
        rst       = 1'b1;
        rx        = 1'b1;
        out_ready = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_data",  {24'd0, out_data}, 32'h00);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_fe",    {31'd0, frame_err}, 32'd0);
        chk("rst_ov",    {31'd0, overrun}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(4);

        // 1: single byte held until consumed
        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        @(negedge clk);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data",  {24'd0, out_data}, 32'hA5);
        tick(5);
        pulse_ready();
        @(negedge clk);
        chk("t1_cleared", {31'd0, out_valid}, 32'd0);

        // 2: false start
        busy_seen = 1'b0;
        fe0 = fe_seen;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * CPB);
        @(negedge clk);
        chk("t2_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("t2_busy_idle", {31'd0, busy}, 32'd0);
        chk("t2_valid",     {31'd0, out_valid}, 32'd0);
        chk("t2_no_fe",     fe_seen - fe0, 32'd0);

        // 3: framing error
        fe0 = fe_seen;
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        @(negedge clk);
        chk("t3_fe_once", fe_seen - fe0, 32'd1);
        chk("t3_valid",   {31'd0, out_valid}, 32'd0);
        chk("t3_busy",    {31'd0, busy}, 32'd0);

        // 4: overrun on back-to-back frames with no consumer
        ov0 = ov_seen;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(2 * CPB);
        @(negedge clk);
        chk("t4_ov_once", ov_seen - ov0, 32'd1);
        chk("t4_data",    {24'd0, out_data}, 32'h11);
        pulse_ready();
        @(negedge clk);
        chk("t4_cleared", {31'd0, out_valid}, 32'd0);
        chk("t4_data_kept", {24'd0, out_data}, 32'h11);

        // 5: ready tied high, back-to-back with one stop bit
        out_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(2 * CPB);

        // Randomised frames, bytes, stop quality and gaps
        for (int n = 0; n < 16; n++) begin
            logic [7:0] rb;
            bit ok;
            int gap;
            rb  = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2) + (ok ? 0 : 1);
            send_frame(rb, ok);
            tick(gap * CPB);
        end
        tick(2 * CPB);
        @(negedge clk);
        chk("rand_drained", exp_q.size(), 32'd0);

        // 6: reset mid-frame drops a pending byte and the partial frame
        out_ready = 1'b0;
        send_frame(8'h42, 1'b1);
        tick(2 * CPB);
        b77 = 8'h77;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b77[i];
            tick(CPB);
        end
        rx = b77[4];
        tick(CPB / 2);
        rst = 1'b1;
        exp_q.delete();
        hold_full = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data",  {24'd0, out_data}, 32'h00);
        chk("t6_rst_busy",  {31'd0, busy}, 32'd0);
        tick(2);
        rst = 1'b0;
        rx  = 1'b1;
        tick(12 * CPB);
        @(negedge clk);
        chk("t6_post_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_post_data",  {24'd0, out_data}, 32'h00);
        chk("t6_post_busy",  {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1);
        tick(2 * CPB);
        @(negedge clk);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_data",  {24'd0, out_data}, 32'h5A);
        pulse_ready();

        // Drain with a bounded wait, then global totals
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick(1);
        @(negedge clk);
        chk("final_queue", exp_q.size(), 32'd0);
        chk("final_fe",    fe_seen, exp_fe);
        chk("final_ov",    ov_seen, exp_ov);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
